// File: rtl/ptr_walk_gen_if.sv
// Bundle of table-write, start-request and merged output-stream signals for ptr_walk_gen.
// master = requester/consumer side, slave = the walker itself.
interface ptr_walk_gen_if #(
   parameter int PTR_W = 4,
   parameter int N_CH  = 2
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [PTR_W-1:0] wr_data;

   logic             start;
   logic [CH_W-1:0]  start_ch;
   logic [PTR_W-1:0] start_ptr;
   logic             start_ack;
   logic [N_CH-1:0]  busy;

   logic [PTR_W-1:0] out_ptr;
   logic [CH_W-1:0]  out_ch;
   logic             out_last;
   logic             out_ptr_vld;
   logic             out_ready;

   logic [N_CH-1:0]  done;
   logic [N_CH-1:0]  err;

   modport master (
      output wr_en, wr_addr, wr_data,
      output start, start_ch, start_ptr,
      output out_ready,
      input  start_ack, busy,
      input  out_ptr, out_ch, out_last, out_ptr_vld,
      input  done, err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  start, start_ch, start_ptr,
      input  out_ready,
      output start_ack, busy,
      output out_ptr, out_ch, out_last, out_ptr_vld,
      output done, err
   );
endinterface

// File: rtl/ptr_walk_gen.sv
// Multi-channel linked-list walker: next-pointer table, per-channel IDLE/WALK FSMs, round-robin
// merge into one valid/ready stream. Optional loop guard: define PTR_WALK_LOOP_GUARD_EN.
module ptr_walk_gen #(
   parameter int PTR_W = 4,
   parameter int N_CH  = 2
) (
   input logic           clk,
   input logic           rst,
   ptr_walk_gen_if.slave bus
);
   localparam int NODES = 2**PTR_W;
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [PTR_W-1:0] NIL = '1;

   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } ch_state_e;

   logic [PTR_W-1:0] nxt_q [NODES];

   ch_state_e        state_q [N_CH];
   ch_state_e        state_d [N_CH];
   logic [PTR_W-1:0] cur_q   [N_CH];
   logic [PTR_W-1:0] cur_d   [N_CH];
   logic [N_CH-1:0]  done_q;
   logic [N_CH-1:0]  done_d;
   logic [CH_W-1:0]  rr_q;
   logic [CH_W-1:0]  rr_d;

   logic             out_vld_q;
   logic             out_vld_d;
   logic [PTR_W-1:0] out_ptr_q;
   logic [PTR_W-1:0] out_ptr_d;
   logic [CH_W-1:0]  out_ch_q;
   logic [CH_W-1:0]  out_ch_d;
   logic             out_last_q;
   logic             out_last_d;

   logic [N_CH-1:0]  busy_v;
   logic             ch_ok;
   logic             start_ok;
   logic             slot_free;
   logic             gnt_vld;
   logic [CH_W-1:0]  gnt_ch;
   logic [PTR_W-1:0] gnt_nxt;
   logic             abort;

   // ---------------- next-pointer table ----------------
   // Reads are combinational from the flops, so a same-cycle write is seen only after the edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int n = 0; n < NODES; n++) nxt_q[n] <= NIL;
      end else if (bus.wr_en) begin
         nxt_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   // ---------------- start handshake ----------------
   always_comb begin
      for (int i = 0; i < N_CH; i++) busy_v[i] = (state_q[i] == WALK);
   end

   assign ch_ok         = (int'(bus.start_ch) < N_CH);
   assign bus.start_ack = bus.start & ch_ok & ~busy_v[bus.start_ch] & rst;
   assign start_ok      = bus.start_ack;

   // ---------------- round-robin arbiter ----------------
   assign slot_free = ~out_vld_q | bus.out_ready;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (!gnt_vld && slot_free && busy_v[(int'(rr_q) + k) % N_CH]) begin
            gnt_vld = 1'b1;
            gnt_ch  = CH_W'((int'(rr_q) + k) % N_CH);
         end
      end
   end

   assign gnt_nxt = nxt_q[cur_q[gnt_ch]];

   // ---------------- channel FSMs and output register ----------------
   always_comb begin
      out_vld_d  = out_vld_q & ~bus.out_ready;
      out_ptr_d  = out_ptr_q;
      out_ch_d   = out_ch_q;
      out_last_d = out_last_q;
      rr_d       = rr_q;
      done_d     = '0;
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cur_d[i]   = cur_q[i];
      end

      // A NIL head never enters WALK; it just reports completion.
      if (start_ok) begin
         if (bus.start_ptr == NIL) begin
            done_d[bus.start_ch] = 1'b1;
         end else begin
            state_d[bus.start_ch] = WALK;
            cur_d[bus.start_ch]   = bus.start_ptr;
         end
      end

      if (gnt_vld) begin
         rr_d = CH_W'((int'(gnt_ch) + 1) % N_CH);
         if (abort) begin
            state_d[gnt_ch] = IDLE;
            done_d[gnt_ch]  = 1'b1;
         end else begin
            out_vld_d  = 1'b1;
            out_ptr_d  = cur_q[gnt_ch];
            out_ch_d   = gnt_ch;
            out_last_d = (gnt_nxt == NIL);
            if (gnt_nxt == NIL) begin
               state_d[gnt_ch] = IDLE;
               done_d[gnt_ch]  = 1'b1;
            end else begin
               cur_d[gnt_ch] = gnt_nxt;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= IDLE;
            cur_q[i]   <= '0;
         end
         done_q     <= '0;
         rr_q       <= '0;
         out_vld_q  <= 1'b0;
         out_ptr_q  <= '0;
         out_ch_q   <= '0;
         out_last_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cur_q[i]   <= cur_d[i];
         end
         done_q     <= done_d;
         rr_q       <= rr_d;
         out_vld_q  <= out_vld_d;
         out_ptr_q  <= out_ptr_d;
         out_ch_q   <= out_ch_d;
         out_last_q <= out_last_d;
      end
   end

   // ---------------- loop guard ----------------
`ifdef PTR_WALK_LOOP_GUARD_EN
   logic [PTR_W:0]  steps_q [N_CH];
   logic [PTR_W:0]  steps_d [N_CH];
   logic [N_CH-1:0] err_q;
   logic [N_CH-1:0] err_d;

   // NODES emissions already made means the list revisits a node; the next grant aborts.
   assign abort = gnt_vld && (steps_q[gnt_ch] == (PTR_W+1)'(NODES));

   always_comb begin
      err_d = err_q;
      for (int i = 0; i < N_CH; i++) steps_d[i] = steps_q[i];
      if (start_ok) begin
         steps_d[bus.start_ch] = '0;
         err_d[bus.start_ch]   = 1'b0;
      end
      if (gnt_vld) begin
         if (abort) err_d[gnt_ch] = 1'b1;
         else       steps_d[gnt_ch] = steps_q[gnt_ch] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) steps_q[i] <= '0;
         err_q <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) steps_q[i] <= steps_d[i];
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign abort   = 1'b0;
   assign bus.err = '0;
`endif

   assign bus.busy        = busy_v;
   assign bus.done        = done_q;
   assign bus.out_ptr     = out_ptr_q;
   assign bus.out_ch      = out_ch_q;
   assign bus.out_last    = out_last_q;
   assign bus.out_ptr_vld = out_vld_q;
endmodule

// File: tb/tb_ptr_walk_gen.sv
// Directed bench for ptr_walk_gen (PTR_W=4, N_CH=2, NIL=15); follows PTR_WALK_LOOP_GUARD_EN if defined.
module tb_ptr_walk_gen;
   localparam int PTR_W = 4;
   localparam int N_CH  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ptr_walk_gen_if #(.PTR_W(PTR_W), .N_CH(N_CH)) bus ();

   ptr_walk_gen #(.PTR_W(PTR_W), .N_CH(N_CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic out(input string tag, input logic vld, input int ptr, input int ch, input logic last);
      chk({tag, "_vld"}, 32'(bus.out_ptr_vld), 32'(vld));
      chk({tag, "_ptr"}, 32'(bus.out_ptr), 32'(ptr));
      chk({tag, "_ch"}, 32'(bus.out_ch), 32'(ch));
      chk({tag, "_last"}, 32'(bus.out_last), 32'(last));
   endtask

   task automatic wr(input int addr, input int data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = PTR_W'(addr);
      bus.wr_data = PTR_W'(data);
      cyc();
      bus.wr_en   = 1'b0;
   endtask

   task automatic go(input string tag, input int ch, input int ptr, input logic ack);
      bus.start     = 1'b1;
      bus.start_ch  = 1'(ch);
      bus.start_ptr = PTR_W'(ptr);
      #1;
      chk({tag, "_ack"}, 32'(bus.start_ack), 32'(ack));
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.start_ch = '0; bus.start_ptr = '0;
      bus.out_ready = 1'b1;

      // reset state
      rst = 1'b0;
      cyc(); cyc();
      out("rst", 1'b0, 0, 0, 1'b0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err", 32'(bus.err), 0);
      rst = 1'b1;

      // single walk 2 -> 5 -> 9
      wr(2, 5); wr(5, 9); wr(9, 15);
      go("s1", 0, 2, 1'b1);
      cyc(); bus.start = 1'b0;
      chk("s1_busy", 32'(bus.busy), 1);
      chk("s1_novld", 32'(bus.out_ptr_vld), 0);
      cyc(); out("s1_a", 1'b1, 2, 0, 1'b0); chk("s1_a_done", 32'(bus.done), 0);
      cyc(); out("s1_b", 1'b1, 5, 0, 1'b0);
      cyc(); out("s1_c", 1'b1, 9, 0, 1'b1);
      chk("s1_c_done", 32'(bus.done), 1);
      chk("s1_c_busy", 32'(bus.busy), 0);
      cyc(); chk("s1_end_vld", 32'(bus.out_ptr_vld), 0); chk("s1_end_done", 32'(bus.done), 0);

      // interleave: ch0 @2, ch1 @3 one cycle apart
      wr(3, 7); wr(7, 15);
      go("s2_0", 0, 2, 1'b1);
      cyc();
      go("s2_1", 1, 3, 1'b1);
      cyc(); bus.start = 1'b0;
      out("s2_a", 1'b1, 2, 0, 1'b0);
      cyc(); out("s2_b", 1'b1, 3, 1, 1'b0);
      cyc(); out("s2_c", 1'b1, 5, 0, 1'b0);
      cyc(); out("s2_d", 1'b1, 7, 1, 1'b1); chk("s2_d_done", 32'(bus.done), 2);
      cyc(); out("s2_e", 1'b1, 9, 0, 1'b1); chk("s2_e_done", 32'(bus.done), 1);
      chk("s2_e_busy", 32'(bus.busy), 0);

      // backpressure for 3 cycles, with a dropped start to the busy channel
      go("s3", 0, 2, 1'b1);
      cyc(); bus.start = 1'b0;
      chk("s3_novld", 32'(bus.out_ptr_vld), 0);
      cyc(); out("s3_a", 1'b1, 2, 0, 1'b0);
      bus.out_ready = 1'b0;
      go("s4_busy", 0, 3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(); bus.start = 1'b0;
         out($sformatf("s3_hold%0d", i), 1'b1, 2, 0, 1'b0);
         chk($sformatf("s3_hold%0d_busy", i), 32'(bus.busy), 1);
      end
      bus.out_ready = 1'b1;
      cyc(); out("s3_b", 1'b1, 5, 0, 1'b0);
      cyc(); out("s3_c", 1'b1, 9, 0, 1'b1); chk("s3_c_done", 32'(bus.done), 1);

      // NIL start: acknowledged, no output, done next cycle
      go("s4_nil", 1, 15, 1'b1);
      cyc(); bus.start = 1'b0;
      chk("s4_vld", 32'(bus.out_ptr_vld), 0);
      chk("s4_done", 32'(bus.done), 2);
      chk("s4_busy", 32'(bus.busy), 0);
      cyc(); chk("s4_done_clr", 32'(bus.done), 0);

      // self-loop 1 -> 1
      wr(1, 1);
      go("s5", 0, 1, 1'b1);
      cyc(); bus.start = 1'b0;
      chk("s5_novld", 32'(bus.out_ptr_vld), 0);
`ifdef PTR_WALK_LOOP_GUARD_EN
      for (int i = 0; i < 16; i++) begin
         cyc(); out($sformatf("s5_loop%0d", i), 1'b1, 1, 0, 1'b0);
      end
      cyc();
      chk("s5_abort_vld", 32'(bus.out_ptr_vld), 0);
      chk("s5_abort_done", 32'(bus.done), 1);
      chk("s5_abort_err", 32'(bus.err), 1);
      chk("s5_abort_busy", 32'(bus.busy), 0);
      go("s5_clr", 0, 15, 1'b1);
      cyc(); bus.start = 1'b0;
      chk("s5_clr_err", 32'(bus.err), 0);
      chk("s5_clr_done", 32'(bus.done), 1);
`else
      for (int i = 0; i < 20; i++) begin
         cyc(); out($sformatf("s5_loop%0d", i), 1'b1, 1, 0, 1'b0);
         chk($sformatf("s5_loop%0d_busy", i), 32'(bus.busy), 1);
      end
`endif

      // reset mid-walk during the interleave scenario
      rst = 1'b0; cyc(); rst = 1'b1;
      wr(2, 5); wr(5, 9); wr(9, 15); wr(3, 7); wr(7, 15);
      go("s6_0", 0, 2, 1'b1);
      cyc();
      go("s6_1", 1, 3, 1'b1);
      cyc(); bus.start = 1'b0;
      out("s6_a", 1'b1, 2, 0, 1'b0);
      cyc(); out("s6_b", 1'b1, 3, 1, 1'b0);
      rst = 1'b0; cyc(); rst = 1'b1;
      chk("s6_rst_vld", 32'(bus.out_ptr_vld), 0);
      chk("s6_rst_busy", 32'(bus.busy), 0);
      chk("s6_rst_done", 32'(bus.done), 0);
      chk("s6_rst_err", 32'(bus.err), 0);
      cyc(); chk("s6_nodone", 32'(bus.done), 0);
      go("s6_re", 0, 2, 1'b1);
      cyc(); bus.start = 1'b0;
      cyc(); out("s6_c", 1'b1, 2, 0, 1'b1);
      chk("s6_c_done", 32'(bus.done), 1);
      chk("s6_c_busy", 32'(bus.busy), 0);
      cyc(); chk("s6_end_vld", 32'(bus.out_ptr_vld), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ptr_walk_gen.md
# ptr_walk_gen

Parametrised multi-channel pointer request generator for the linked-list demo. It holds a next-pointer table for every node and walks lists independently on N_CH channels, each starting from a head pointer supplied by the requester. Visited pointers are merged into one valid/ready output stream by a round-robin arbiter. The block replaces the free-running single-stream request generator in the step-6 design and feeds the same downstream pointer consumer.

## Interface
- PTR_W, 4: pointer width; table holds NODES = 2**PTR_W entries; NIL = all ones (2**PTR_W-1).
- N_CH, 2: number of independent walk channels (1..8); CH_W = max(1, $clog2(N_CH)).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets at the next rising edge).
- wr_en  in  1  table write strobe.
- wr_addr  in  PTR_W  node being written.
- wr_data  in  PTR_W  next pointer of that node.
- start  in  1  start request.
- start_ch  in  CH_W  target channel.
- start_ptr  in  PTR_W  head pointer.
- start_ack  out  1  combinational: start & ~busy[start_ch] & rst.
- busy  out  N_CH  channel is walking (registered).
- out_ptr  out  PTR_W  emitted pointer.
- out_ch  out  CH_W  channel that produced out_ptr.
- out_last  out  1  out_ptr is the final node of its walk.
- out_ptr_vld  out  1  output valid.
- out_ready  in  1  consumer accepts the output this cycle.
- done  out  N_CH  one-cycle pulse per channel when its walk finishes.
- err  out  N_CH  sticky loop-guard abort flag (tied to 0 without the macro).

## Operation
- Table: NODES x PTR_W flops, reset to NIL. Write takes effect at the edge. A same-cycle read of wr_addr returns the old value.
- Per-channel FSM, IDLE -> WALK -> IDLE. Registers per channel: cur (PTR_W) and busy.
- Accepted start with start_ptr != NIL: cur <= start_ptr, enter WALK.
- Accepted start with start_ptr == NIL: stay IDLE, pulse done[ch] next cycle, emit nothing.
- Start to a busy channel: start_ack=0; the request is dropped and the walk is unaffected.
- Arbiter: eligible channels = WALK. A grant happens when the output register is empty or being drained (out_ptr_vld & out_ready).
  - Pick the first eligible channel at or after the round-robin pointer.
  - The pointer moves to granted+1 mod N_CH.
- Granted channel loads the output register: out_ptr <= cur, out_ch, out_last <= (table[cur]==NIL).
  - If table[cur]==NIL: channel returns to IDLE and done pulses in the same cycle out_ptr_vld rises.
  - Otherwise cur <= table[cur].
- Output register holds all fields stable while out_ptr_vld & ~out_ready.

## Timing
- Reset: out_ptr_vld=0, out_ptr=0, out_ch=0, out_last=0, done=0, busy=0, err=0, RR pointer=0, table all NIL. A walk in progress is abandoned without a done pulse.
- Start sampled at edge t: busy=1 after t; earliest grant in cycle t+1; out_ptr_vld=1 after edge t+1.
- Throughput: one pointer per cycle in aggregate while out_ready=1. Per-channel rate is 1/k with k eligible channels.
- A start to a channel in the same cycle that channel finishes is rejected (busy still 1).
- Table write in the same cycle as a grant reading that node: the old next pointer is used.

## Configuration
- PTR_WALK_LOOP_GUARD_EN defined: each channel keeps a PTR_W+1-bit step counter, cleared on start and incremented per grant.
  - When a grant would be step NODES+1, the channel aborts instead: no emission, busy=0, done pulse, err[ch] set.
  - err[ch] is cleared by the next accepted start on that channel or by reset.
  - A list of exactly NODES distinct nodes is not an error.
- Undefined: no counters; cyclic lists walk forever; err tied to 0.

## Test plan
PTR_W=4, N_CH=2, NIL=15.
- Single walk: write next[2]=5, next[5]=9, next[9]=15; start ch0 at 2 with out_ready=1 -> out_ptr 2,5,9 on three consecutive cycles, out_last only on 9, done[0] pulse with 9, busy[0] drops.
- Interleave: add next[3]=7, next[7]=15; start ch0@2 and ch1@3 one cycle apart -> order 2/ch0, 3/ch1, 5/ch0, 7/ch1(last), 9/ch0(last).
- Backpressure: hold out_ready=0 for 3 cycles mid-walk -> out_ptr/out_ch/out_last stable, no pointer lost or duplicated; sequence resumes on release.
- Start rules: start ch0 while busy -> start_ack=0, walk unchanged; start ch1 at 15 -> start_ack=1, no output, done[1] pulse next cycle.
- Loop guard: next[1]=1, start ch0 at 1 -> with macro: exactly 16 emissions of 1, then err[0]=1, done[0] pulse, busy[0]=0; without macro: out_ptr=1 every cycle indefinitely.
- Reset mid-walk: rst=0 for one cycle during scenario 2 -> after that edge out_ptr_vld=0, busy=0, done=0, and a restart at 2 emits only 2 (table NIL).
